// File: rtl/char_ram_writer_arb_if.sv
// Client request bus and character-RAM write bus of char_ram_writer_arb.
// The slave modport is the arbiter side; the master modport is clients plus RAM.
interface char_ram_writer_arb_if #(
  parameter int AW = 12,
  parameter int DW = 8
);
  logic [2:0]    req_valid;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic [AW-1:0] req_addr2;
  logic [DW-1:0] req_data0;
  logic [DW-1:0] req_data1;
  logic [DW-1:0] req_data2;
  logic [2:0]    req_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    output req_valid, req_addr0, req_addr1, req_addr2,
           req_data0, req_data1, req_data2,
    input  req_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  req_valid, req_addr0, req_addr1, req_addr2,
           req_data0, req_data1, req_data2,
    output req_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/char_ram_writer_arb.sv
// Write-port arbiter and full-screen fill engine for the 70x30 character RAM.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module char_ram_writer_arb #(
  parameter int CELLS = 2100,
  parameter int AW    = 12,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_value,
  output logic          fill_busy,
  output logic          fill_done,
  output logic          oob,
  char_ram_writer_arb_if.slave bus
);
  localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);

  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_next;

  logic [AW-1:0] fill_cnt;
  logic [DW-1:0] fill_char;
  logic [2:0]    grant;
  logic          handshake;
  logic          fill_accept;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0] last_grant;
  logic [1:0] rr_idx;
  logic       rr_found;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fill_accept) state_next = FILL;
      FILL:    if (ce && fill_cnt == LAST_CELL) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Grant is gated by reset so req_ready reads 0 while reset is held.
  always_comb begin
    grant = 3'b000;
`ifdef ARB_ROUND_ROBIN_EN
    rr_idx   = 2'd0;
    rr_found = 1'b0;
`endif
    if (state == IDLE && ce && reset_n) begin
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= 3; k++) begin
        rr_idx = 2'((int'(last_grant) + k) % 3);
        if (!rr_found && bus.req_valid[rr_idx]) begin
          grant[rr_idx] = 1'b1;
          rr_found      = 1'b1;
        end
      end
`else
      if      (bus.req_valid[0]) grant = 3'b001;
      else if (bus.req_valid[1]) grant = 3'b010;
      else if (bus.req_valid[2]) grant = 3'b100;
`endif
    end
    handshake   = |grant;
    fill_accept = (state == IDLE) && ce && fill_start;
    fill_busy   = (state == FILL) || fill_done;
    sel_addr    = bus.req_addr0;
    sel_data    = bus.req_data0;
    if (grant[1]) begin
      sel_addr = bus.req_addr1;
      sel_data = bus.req_data1;
    end else if (grant[2]) begin
      sel_addr = bus.req_addr2;
      sel_data = bus.req_data2;
    end
  end

  // Fill writes and client writes share one registered write stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      oob       <= 1'b0;
      fill_done <= 1'b0;
      fill_cnt  <= '0;
      fill_char <= '0;
    end else begin
      wr_en_q   <= 1'b0;
      oob       <= 1'b0;
      fill_done <= 1'b0;
      if (state == FILL) begin
        if (ce) begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= fill_cnt;
          wr_data_q <= fill_char;
          if (fill_cnt == LAST_CELL) fill_done <= 1'b1;
          else                       fill_cnt  <= fill_cnt + 1'b1;
        end
      end else begin
        if (handshake) begin
          wr_addr_q <= sel_addr;
          wr_data_q <= sel_data;
          if (sel_addr > LAST_CELL) oob     <= 1'b1;
          else                      wr_en_q <= 1'b1;
        end
        if (fill_accept) begin
          fill_cnt  <= '0;
          fill_char <= fill_value;
        end
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 2'd2;
    end else if (handshake) begin
      if      (grant[0]) last_grant <= 2'd0;
      else if (grant[1]) last_grant <= 2'd1;
      else               last_grant <= 2'd2;
    end
  end
`endif

  assign bus.req_ready = grant;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
endmodule
